// File: rtl/rs_multi_cdb.sv
// rtl/rs_multi_cdb.sv - reservation station with multi-channel CDB wakeup and age-ordered issue
module rs_multi_cdb #(
  parameter int DEPTH  = 16,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32,
  parameter int OP_W   = 6,
  parameter int CDB_N  = 3,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      flush,
  input  logic                      disp_valid,
  output logic                      disp_ready,
  input  logic [OP_W-1:0]           disp_op,
  input  logic [DATA_W-1:0]         disp_vj,
  input  logic [DATA_W-1:0]         disp_vk,
  input  logic                      disp_qj_wait,
  input  logic                      disp_qk_wait,
  input  logic [TAG_W-1:0]          disp_qj,
  input  logic [TAG_W-1:0]          disp_qk,
  input  logic [DATA_W-1:0]         disp_imm,
  input  logic [DATA_W-1:0]         disp_pc,
  input  logic [TAG_W-1:0]          disp_tag,
  input  logic [CDB_N-1:0]          cdb_valid,
  input  logic [CDB_N*TAG_W-1:0]    cdb_tag,
  input  logic [CDB_N*DATA_W-1:0]   cdb_data,
  output logic                      iss_valid,
  input  logic                      iss_ready,
  output logic [OP_W-1:0]           iss_op,
  output logic [DATA_W-1:0]         iss_vj,
  output logic [DATA_W-1:0]         iss_vk,
  output logic [DATA_W-1:0]         iss_imm,
  output logic [DATA_W-1:0]         iss_pc,
  output logic [TAG_W-1:0]          iss_tag,
  output logic [CNT_W-1:0]          count,
  output logic                      full,
  output logic                      empty
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0]  busy, qj_wait, qk_wait;
  logic [OP_W-1:0]   e_op  [DEPTH];
  logic [DATA_W-1:0] e_vj  [DEPTH];
  logic [DATA_W-1:0] e_vk  [DEPTH];
  logic [TAG_W-1:0]  e_qj  [DEPTH];
  logic [TAG_W-1:0]  e_qk  [DEPTH];
  logic [DATA_W-1:0] e_imm [DEPTH];
  logic [DATA_W-1:0] e_pc  [DEPTH];
  logic [TAG_W-1:0]  e_tag [DEPTH];
  // older[j][i] set means entry j was dispatched before entry i
  logic [DEPTH-1:0]  older [DEPTH];

  logic [DEPTH-1:0]  ready, wins;
  logic [IDX_W-1:0]  sel_idx, free_idx;
  logic              disp_fire, iss_fire;
  logic [DATA_W:0]   dj, dk;
  logic [DATA_W:0]   wj [DEPTH];
  logic [DATA_W:0]   wk [DEPTH];

  // {hit, data}; iterating downward lets the lowest matching channel win
  function automatic logic [DATA_W:0] cdb_match(input logic [TAG_W-1:0] q);
    logic [DATA_W:0] r;
    r = '0;
    for (int c = CDB_N - 1; c >= 0; c--) begin
      if (cdb_valid[c] && cdb_tag[c*TAG_W +: TAG_W] == q)
        r = {1'b1, cdb_data[c*DATA_W +: DATA_W]};
    end
    return r;
  endfunction

  assign ready      = busy & ~qj_wait & ~qk_wait;
  assign disp_ready = rdy & ~flush & (count < CNT_W'(DEPTH));
  assign disp_fire  = disp_valid & disp_ready;
  assign iss_valid  = rdy & ~flush & (|ready);
  assign iss_fire   = iss_valid & iss_ready;
  assign full       = (count == CNT_W'(DEPTH));
  assign empty      = (count == '0);
  assign dj         = cdb_match(disp_qj);
  assign dk         = cdb_match(disp_qk);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      wj[i] = cdb_match(e_qj[i]);
      wk[i] = cdb_match(e_qk[i]);
    end
  end

  // An entry wins when no older entry is also ready; at most one can win
  always_comb begin
    wins    = '0;
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wins[i] = ready[i];
      for (int j = 0; j < DEPTH; j++)
        if (ready[j] && older[j][i]) wins[i] = 1'b0;
    end
    for (int i = 0; i < DEPTH; i++)
      if (wins[i]) sel_idx = IDX_W'(i);
  end

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!busy[i]) free_idx = IDX_W'(i);
  end

  always_comb begin
    iss_op  = '0;
    iss_vj  = '0;
    iss_vk  = '0;
    iss_imm = '0;
    iss_pc  = '0;
    iss_tag = '0;
    if (iss_valid) begin
      iss_op  = e_op[sel_idx];
      iss_vj  = e_vj[sel_idx];
      iss_vk  = e_vk[sel_idx];
      iss_imm = e_imm[sel_idx];
      iss_pc  = e_pc[sel_idx];
      iss_tag = e_tag[sel_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= '0;
      qj_wait <= '0;
      qk_wait <= '0;
      count   <= '0;
      for (int i = 0; i < DEPTH; i++) older[i] <= '0;
    end else if (rdy) begin
      if (flush) begin
        busy    <= '0;
        qj_wait <= '0;
        qk_wait <= '0;
        count   <= '0;
        for (int i = 0; i < DEPTH; i++) older[i] <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (busy[i] && qj_wait[i] && wj[i][DATA_W]) qj_wait[i] <= 1'b0;
          if (busy[i] && qk_wait[i] && wk[i][DATA_W]) qk_wait[i] <= 1'b0;
        end
        if (iss_fire) busy[sel_idx] <= 1'b0;
        if (disp_fire) begin
          busy[free_idx]    <= 1'b1;
          qj_wait[free_idx] <= disp_qj_wait & ~dj[DATA_W];
          qk_wait[free_idx] <= disp_qk_wait & ~dk[DATA_W];
          older[free_idx]   <= '0;
          for (int j = 0; j < DEPTH; j++)
            older[j][free_idx] <= busy[j] & ~(iss_fire && sel_idx == IDX_W'(j));
        end
        count <= count + CNT_W'(disp_fire) - CNT_W'(iss_fire);
      end
    end
  end

  // Payload needs no reset: it is only observed while the busy bit is set
  always_ff @(posedge clk) begin
    if (rdy && !flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy[i] && qj_wait[i] && wj[i][DATA_W]) e_vj[i] <= wj[i][DATA_W-1:0];
        if (busy[i] && qk_wait[i] && wk[i][DATA_W]) e_vk[i] <= wk[i][DATA_W-1:0];
      end
      if (disp_fire) begin
        e_op[free_idx]  <= disp_op;
        e_vj[free_idx]  <= (disp_qj_wait && dj[DATA_W]) ? dj[DATA_W-1:0] : disp_vj;
        e_vk[free_idx]  <= (disp_qk_wait && dk[DATA_W]) ? dk[DATA_W-1:0] : disp_vk;
        e_qj[free_idx]  <= disp_qj;
        e_qk[free_idx]  <= disp_qk;
        e_imm[free_idx] <= disp_imm;
        e_pc[free_idx]  <= disp_pc;
        e_tag[free_idx] <= disp_tag;
      end
    end
  end

endmodule

// File: tb/tb_rs_multi_cdb.sv
// tb/tb_rs_multi_cdb.sv - directed and randomized checks of rs_multi_cdb against an age-ordered list model
module tb_rs_multi_cdb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy, flush, disp_valid, disp_ready;
  logic [5:0]  disp_op;
  logic [31:0] disp_vj, disp_vk, disp_imm, disp_pc;
  logic        disp_qj_wait, disp_qk_wait;
  logic [3:0]  disp_qj, disp_qk, disp_tag;
  logic [2:0]  cdb_valid;
  logic [11:0] cdb_tag;
  logic [95:0] cdb_data;
  logic        iss_valid, iss_ready;
  logic [5:0]  iss_op;
  logic [31:0] iss_vj, iss_vk, iss_imm, iss_pc;
  logic [3:0]  iss_tag;
  logic [4:0]  count;
  logic        full, empty;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] vj, vk, imm, pc;
    logic        jw, kw;
    logic [3:0]  qj, qk, tag;
  } ent_t;

  // Entries kept in dispatch order; front is oldest
  ent_t mq[$];

  rs_multi_cdb dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_vj(disp_vj), .disp_vk(disp_vk), .disp_qj_wait(disp_qj_wait),
    .disp_qk_wait(disp_qk_wait), .disp_qj(disp_qj), .disp_qk(disp_qk),
    .disp_imm(disp_imm), .disp_pc(disp_pc), .disp_tag(disp_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
    .iss_vj(iss_vj), .iss_vk(iss_vk), .iss_imm(iss_imm), .iss_pc(iss_pc),
    .iss_tag(iss_tag), .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit lookup(input logic [3:0] q, output logic [31:0] d);
    d = '0;
    for (int c = 0; c < 3; c++) begin
      if (cdb_valid[c] && cdb_tag[c*4 +: 4] == q) begin
        d = cdb_data[c*32 +: 32];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic idle();
    rdy = 1'b1; flush = 1'b0; disp_valid = 1'b0; iss_ready = 1'b0;
    disp_op = '0; disp_vj = '0; disp_vk = '0; disp_imm = '0; disp_pc = '0;
    disp_qj_wait = 1'b0; disp_qk_wait = 1'b0; disp_qj = '0; disp_qk = '0; disp_tag = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
  endtask

  task automatic set_disp(input logic [3:0] tag, input logic [31:0] vj, input logic [31:0] vk,
                          input logic jw, input logic [3:0] qj);
    disp_valid = 1'b1; disp_tag = tag; disp_op = 6'(tag + 1);
    disp_vj = vj; disp_vk = vk; disp_qj_wait = jw; disp_qj = qj;
    disp_qk_wait = 1'b0; disp_qk = '0;
    disp_imm = 32'(tag) * 16; disp_pc = 32'h1000 + 32'(tag) * 4;
  endtask

  task automatic set_cdb(input int ch, input logic [3:0] tag, input logic [31:0] data);
    cdb_valid[ch] = 1'b1;
    cdb_tag[ch*4 +: 4] = tag;
    cdb_data[ch*32 +: 32] = data;
  endtask

  // Called at a falling edge with inputs applied: checks outputs, advances the model, moves one cycle
  task automatic step();
    int oi;
    bit exp_iss, acc;
    ent_t e, z;
    logic [31:0] d;
    #1;
    oi = -1;
    for (int i = 0; i < mq.size(); i++)
      if (!mq[i].jw && !mq[i].kw) begin oi = i; break; end
    exp_iss = rdy && !flush && oi >= 0;
    acc = rdy && !flush && disp_valid && mq.size() < 16;
    z = '{default: 0};
    e = exp_iss ? mq[oi] : z;
    check_eq("disp_ready", disp_ready, rdy && !flush && mq.size() < 16);
    check_eq("iss_valid", iss_valid, exp_iss);
    check_eq("iss_tag", iss_tag, e.tag);
    check_eq("iss_op", iss_op, e.op);
    check_eq("iss_vj", iss_vj, e.vj);
    check_eq("iss_vk", iss_vk, e.vk);
    check_eq("iss_imm", iss_imm, e.imm);
    check_eq("iss_pc", iss_pc, e.pc);
    check_eq("count", count, mq.size());
    check_eq("full", full, mq.size() == 16);
    check_eq("empty", empty, mq.size() == 0);
    if (rdy) begin
      if (flush) mq.delete();
      else begin
        if (exp_iss && iss_ready) mq.delete(oi);
        for (int i = 0; i < mq.size(); i++) begin
          e = mq[i];
          if (e.jw && lookup(e.qj, d)) begin e.vj = d; e.jw = 1'b0; end
          if (e.kw && lookup(e.qk, d)) begin e.vk = d; e.kw = 1'b0; end
          mq[i] = e;
        end
        if (acc) begin
          e.op = disp_op; e.vj = disp_vj; e.vk = disp_vk; e.imm = disp_imm;
          e.pc = disp_pc; e.tag = disp_tag; e.qj = disp_qj; e.qk = disp_qk;
          e.jw = disp_qj_wait; e.kw = disp_qk_wait;
          if (e.jw && lookup(e.qj, d)) begin e.vj = d; e.jw = 1'b0; end
          if (e.kw && lookup(e.qk, d)) begin e.vk = d; e.kw = 1'b0; end
          mq.push_back(e);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int p_disp, p_iss;
    idle();
    #3;
    check_eq("rst_iss_valid", iss_valid, 0);
    check_eq("rst_disp_ready", disp_ready, 1);
    check_eq("rst_empty", empty, 1);
    check_eq("rst_full", full, 0);
    check_eq("rst_count", count, 0);
    check_eq("rst_iss_tag", iss_tag, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // simple ready op issues one cycle after dispatch
    set_disp(4'd3, 32'd5, 32'd7, 1'b0, 4'd0);
    step();
    idle();
    check_eq("t1_valid", iss_valid, 1);
    check_eq("t1_tag", iss_tag, 3);
    check_eq("t1_vj", iss_vj, 5);
    check_eq("t1_vk", iss_vk, 7);
    iss_ready = 1'b1;
    step();
    idle();
    step();
    check_eq("t1_empty", empty, 1);

    // wakeup from channel 1
    set_disp(4'd1, 32'd0, 32'd2, 1'b1, 4'd9);
    iss_ready = 1'b1;
    step();
    disp_valid = 1'b0;
    step();
    set_cdb(1, 4'd9, 32'h1234);
    step();
    cdb_valid = '0;
    check_eq("t2_valid", iss_valid, 1);
    check_eq("t2_vj", iss_vj, 32'h1234);
    step();

    // age order after a common wakeup on channel 2
    idle();
    set_disp(4'd2, 32'd0, 32'd1, 1'b1, 4'd8); step();
    set_disp(4'd5, 32'd0, 32'd1, 1'b1, 4'd8); step();
    set_disp(4'd6, 32'd0, 32'd1, 1'b1, 4'd8); step();
    idle();
    set_cdb(2, 4'd8, 32'hBEEF);
    iss_ready = 1'b1;
    step();
    cdb_valid = '0;
    check_eq("t3_first", iss_tag, 2);
    step();
    check_eq("t3_second", iss_tag, 5);
    step();
    check_eq("t3_third", iss_tag, 6);
    step();
    check_eq("t3_empty", empty, 1);

    // fill, reject extra dispatch, hold selection under backpressure
    idle();
    for (int i = 0; i < 16; i++) begin
      set_disp(4'(i), 32'(i), 32'(i * 3), 1'b1, 4'd15);
      step();
    end
    check_eq("t4_full", full, 1);
    check_eq("t4_disp_ready", disp_ready, 0);
    set_disp(4'd7, 32'd1, 32'd1, 1'b0, 4'd0);
    step();
    check_eq("t4_count", count, 16);
    idle();
    set_cdb(0, 4'd15, 32'h5555);
    step();
    cdb_valid = '0;
    for (int i = 0; i < 3; i++) begin
      check_eq("t4_hold", iss_tag, 0);
      step();
    end
    iss_ready = 1'b1;
    for (int i = 0; i < 17; i++) step();
    check_eq("t4_drained", empty, 1);

    // same-cycle bypass on dispatch
    idle();
    set_disp(4'd4, 32'd0, 32'd9, 1'b1, 4'd4);
    set_cdb(0, 4'd4, 32'hAA);
    iss_ready = 1'b1;
    step();
    idle();
    iss_ready = 1'b1;
    check_eq("t5_valid", iss_valid, 1);
    check_eq("t5_vj", iss_vj, 32'hAA);
    step();

    // flush beats dispatch and wakeup, then async reset mid-cycle
    idle();
    for (int i = 0; i < 5; i++) begin
      set_disp(4'(i + 8), 32'd0, 32'd0, 1'b1, 4'd12);
      step();
    end
    set_disp(4'd1, 32'd1, 32'd1, 1'b0, 4'd0);
    set_cdb(0, 4'd12, 32'h77);
    flush = 1'b1;
    iss_ready = 1'b1;
    step();
    idle();
    #1;
    check_eq("t6_flush_count", count, 0);
    check_eq("t6_flush_iss", iss_valid, 0);
    for (int i = 0; i < 3; i++) begin
      set_disp(4'(i), 32'd0, 32'd0, 1'b1, 4'd12);
      step();
    end
    idle();
    #2;
    rst = 1'b1;
    #1;
    check_eq("t6_rst_count", count, 0);
    check_eq("t6_rst_empty", empty, 1);
    mq.delete();
    @(negedge clk);
    rst = 1'b0;
    step();

    // randomized traffic in phases of differing pressure
    for (int ph = 0; ph < 4; ph++) begin
      case (ph)
        0: begin p_disp = 80; p_iss = 30; end
        1: begin p_disp = 50; p_iss = 50; end
        2: begin p_disp = 30; p_iss = 90; end
        default: begin p_disp = 90; p_iss = 10; end
      endcase
      for (int n = 0; n < 700; n++) begin
        rdy = ($urandom_range(0, 9) != 0);
        flush = ($urandom_range(0, 59) == 0);
        disp_valid = ($urandom_range(0, 99) < p_disp);
        iss_ready = ($urandom_range(0, 99) < p_iss);
        disp_op = 6'($urandom);
        disp_vj = $urandom; disp_vk = $urandom;
        disp_imm = $urandom; disp_pc = $urandom;
        disp_tag = 4'($urandom);
        disp_qj_wait = 1'($urandom); disp_qk_wait = 1'($urandom);
        disp_qj = 4'($urandom_range(0, 5)); disp_qk = 4'($urandom_range(0, 5));
        cdb_valid = 3'($urandom);
        for (int c = 0; c < 3; c++) begin
          cdb_tag[c*4 +: 4] = 4'($urandom_range(0, 5));
          cdb_data[c*32 +: 32] = $urandom;
        end
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rs_multi_cdb.md
Name: rs_multi_cdb

Overview:
Parametrised reservation station, successor to the single-broadcast RS. It holds DEPTH dispatched ALU/branch ops, each waiting on up to two ROB tags. It wakes operands from CDB_N parallel result broadcast channels (ALU, LSB, ROB commit) and issues the oldest ready entry to the execute unit over a valid/ready handshake. It sits between the instruction queue/decoder and the EX unit, and is flushed on branch misprediction.

Parameters:
DEPTH, 16, number of entries (power of 2, ≥2)
TAG_W, 4, ROB tag width
DATA_W, 32, operand/result width
OP_W, 6, ordertype code width
CDB_N, 3, number of wakeup broadcast channels
CNT_W, $clog2(DEPTH)+1, occupancy counter width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
rdy  in  1  global enable; low = freeze
flush  in  1  clear all entries (mispredict)
disp_valid  in  1  dispatch request
disp_ready  out  1  entry available and accepting
disp_op  in  OP_W  ordertype
disp_vj / disp_vk  in  DATA_W  operand values (used when not waiting)
disp_qj_wait / disp_qk_wait  in  1  operand waits on tag
disp_qj / disp_qk  in  TAG_W  producer ROB tags
disp_imm  in  DATA_W  immediate (A)
disp_pc  in  DATA_W  instruction pc
disp_tag  in  TAG_W  destination ROB tag
cdb_valid  in  CDB_N  per-channel broadcast valid
cdb_tag  in  CDB_N*TAG_W  channel c at [c*TAG_W +: TAG_W]
cdb_data  in  CDB_N*DATA_W  channel c at [c*DATA_W +: DATA_W]
iss_valid  out  1  ready entry presented
iss_ready  in  1  EX accepts
iss_op, iss_vj, iss_vk, iss_imm, iss_pc, iss_tag  out  as dispatch  selected entry fields
count  out  CNT_W  occupied entries
full / empty  out  1  count==DEPTH / count==0

Behaviour:
- Entry state: busy, op, vj, vk, qj_wait, qk_wait, qj, qk, imm, pc, tag. Waiting is a separate bit; there is no -1 tag sentinel.
- Reset (async): all busy=0, all wait bits=0, age matrix=0, count=0. Data fields are don't-care. After reset: iss_valid=0, disp_ready=1, empty=1, full=0. Issue field outputs are 0 while iss_valid=0.
- disp_ready = rdy & !flush & (count<DEPTH). It is derived from registered state only and does not depend on the same-cycle issue.
- Dispatch fires when disp_valid&disp_ready. It writes the lowest-index non-busy slot.
- Dispatch bypass: if the operand waits and any cdb_valid[c] has cdb_tag[c]==q in the same cycle, the entry stores cdb_data[c] with wait=0.
- Wakeup: each edge, for every busy entry with qX_wait and a matching valid channel, set vX=data and wait=0. If several channels match, the lowest channel index wins.
- Ready: busy & !qj_wait & !qk_wait (registered state). There is no combinational CDB→issue path. Minimum latency is dispatch→issue 1 cycle and broadcast→issue 1 cycle.
- Age: DEPTH×DEPTH matrix, older[i][j]. On dispatch into k: older[j][k]=busy[j] (excluding j issuing this cycle), older[k][*]=0.
- Selection picks the ready i with no ready j where older[j][i]. The choice is unique.
- iss_valid = rdy & !flush & any ready. Outputs are combinational from the selected entry.
- Issue fires when iss_valid&iss_ready. The selected busy bit clears on the edge. The selection must stay stable while iss_ready is low and no older entry becomes ready.
- count' = count + dispatch_fire − issue_fire. Simultaneous dispatch and issue leaves count unchanged.
- flush (sync, when rdy=1): all busy=0, wait=0, count=0. It overrides same-cycle dispatch, issue, and wakeup.
- rdy=0: no state change. Dispatch, issue, and wakeup are all ignored, including broadcasts presented that cycle.
- Reset mid-operation: all entries are lost immediately. Outputs go to reset values without waiting for a clock.

Test Plan:
1. Reset, then dispatch tag=3, op=ADD, vj=5, vk=7, no waits. Next cycle iss_valid=1, iss_tag=3, vj=5, vk=7. Assert iss_ready → count returns 0, empty=1.
2. Dispatch tag=1 with qj_wait, qj=9; hold iss_ready=1. iss_valid stays 0. Drive cdb_valid=3'b010, cdb_tag[1]=9, data=0x1234. Next cycle iss_valid=1, iss_vj=0x1234.
3. Dispatch A(tag2), B(tag5), C(tag6), all waiting on tag 8. Broadcast tag 8 on channel 2. Issue order is A, B, C on consecutive cycles with iss_ready=1.
4. Fill 16 entries waiting on tag 15 → full=1, disp_ready=0. An extra disp_valid is not accepted and count stays 16. Broadcast tag 15 with iss_ready=0 → iss_valid=1, iss_tag stays the oldest for 3 cycles.
5. Dispatch waiting on tag 4 while cdb_tag[0]=4, valid, data=0xAA in the same cycle → entry issues next cycle with vj=0xAA.
6. With 5 entries held, assert flush together with disp_valid and cdb activity → next cycle count=0, iss_valid=0. Asserting async rst mid-cycle clears count to 0 before the next edge.
